// File: rtl/ctrl_sequencer_pkg.sv
// Shared opcode and FSM state definitions for the multicycle control sequencer.
package definitions;

  typedef enum logic [2:0] {
    kSHIFT = 3'b000,
    kALU   = 3'b001,
    kSTORE = 3'b010,
    kLOAD  = 3'b011,
    kJUMP  = 3'b100,
    kCMP   = 3'b101,
    kBEQ   = 3'b110,
    kMOVE  = 3'b111
  } opcode_e;

  // HALT shares the MOVE opcode; it is the all-ones instruction word.
  localparam logic [2:0] kHALT = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED
  } state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction-word decode: opcode, HALT detect and register-file addresses.
module ctrl_decode
  import definitions::*;
#(
  parameter int unsigned IW   = 9,
  parameter int unsigned RA_W = 3,
  parameter int unsigned ACC  = 0
) (
  input  logic [IW-1:0]   i_ir,
  output opcode_e         o_op,
  output logic            o_is_halt,
  output logic [RA_W-1:0] o_addr_a,
  output logic [RA_W-1:0] o_addr_b,
  output logic [RA_W-1:0] o_addr_w
);

  logic [RA_W-1:0] w_ra;
  logic [RA_W-1:0] w_rb;
  logic [RA_W-1:0] w_acc;

  assign o_op      = opcode_e'(i_ir[IW-1 -: 3]);
  assign o_is_halt = (i_ir[IW-1 -: 3] == kHALT) && (&i_ir);
  assign w_ra      = i_ir[2*RA_W-1 : RA_W];
  assign w_rb      = i_ir[RA_W-1:0];
  assign w_acc     = RA_W'(ACC);

  // Unused address ports stay at zero for each opcode.
  always_comb begin
    o_addr_a = '0;
    o_addr_b = '0;
    o_addr_w = '0;
    unique case (o_op)
      kSHIFT, kCMP: begin
        o_addr_a = w_ra;
        o_addr_b = w_rb;
        o_addr_w = w_ra;
      end
      kALU: begin
        o_addr_a = w_acc;
        o_addr_b = w_rb;
        o_addr_w = w_acc;
      end
      kSTORE, kBEQ: begin
        o_addr_a = w_ra;
        o_addr_b = w_rb;
      end
      kLOAD, kMOVE: begin
        o_addr_a = w_rb;
        o_addr_w = w_ra;
      end
      kJUMP: o_addr_b = w_rb;
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout, HALT and retire counter.
module ctrl_sequencer
  import definitions::*;
#(
  parameter int unsigned IW     = 9,
  parameter int unsigned RA_W   = 3,
  parameter int unsigned ACC    = 0,
  parameter int unsigned MEM_TO = 15,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [IW-1:0]    Instr,
  input  logic             instr_valid,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             fetch_req,
  output logic [RA_W-1:0]  rAddrA,
  output logic [RA_W-1:0]  rAddrB,
  output logic [RA_W-1:0]  wAddr,
  output logic             write_en,
  output logic             ReadMem,
  output logic             WriteMem,
  output logic             jump_en,
  output logic             branch_en,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned TO_W = $clog2(MEM_TO + 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [IW-1:0]   r_ir;
  logic [IW-1:0]   w_ir_nxt;
  logic [TO_W-1:0] r_wait;
  logic            r_beq_exec;
  logic            w_retire;
  logic            w_timeout;
  logic            w_addr_live;
  opcode_e         w_op;
  logic            w_is_halt;
  logic [RA_W-1:0] w_addr_a;
  logic [RA_W-1:0] w_addr_b;
  logic [RA_W-1:0] w_addr_w;

  // Decode the IR value that will be held next cycle so outputs can be registered.
  ctrl_decode #(.IW(IW), .RA_W(RA_W), .ACC(ACC)) u_decode (
    .i_ir      (w_ir_nxt),
    .o_op      (w_op),
    .o_is_halt (w_is_halt),
    .o_addr_a  (w_addr_a),
    .o_addr_b  (w_addr_b),
    .o_addr_w  (w_addr_w)
  );

  // Instruction is accepted only while fetch_req is actually being presented.
  always_comb begin
    w_ir_nxt = r_ir;
    if (r_state == S_FETCH && fetch_req && instr_valid) w_ir_nxt = Instr;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      S_FETCH:  if (fetch_req && instr_valid) w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = w_is_halt ? S_HALTED : S_EXEC;
      S_EXEC: begin
        unique case (w_op)
          kSTORE, kLOAD: w_state_nxt = S_MEM;
          kJUMP, kBEQ: begin
            w_state_nxt = S_FETCH;
            w_retire    = 1'b1;
          end
          default: w_state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        // mem_ready on the final allowed cycle wins over the timeout.
        if (mem_ready) begin
          if (w_op == kSTORE) begin
            w_state_nxt = S_FETCH;
            w_retire    = 1'b1;
          end else begin
            w_state_nxt = S_WB;
          end
        end else if (r_wait == TO_W'(MEM_TO - 1)) begin
          w_state_nxt = S_HALTED;
          w_timeout   = 1'b1;
        end
      end
      S_WB: begin
        w_state_nxt = S_FETCH;
        w_retire    = 1'b1;
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_FETCH;
    endcase
  end

  assign w_addr_live = w_state_nxt inside {S_DECODE, S_EXEC, S_MEM, S_WB};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= S_FETCH;
      r_ir       <= '0;
      r_wait     <= '0;
      r_beq_exec <= 1'b0;
      fetch_req  <= 1'b0;
      rAddrA     <= '0;
      rAddrB     <= '0;
      wAddr      <= '0;
      write_en   <= 1'b0;
      ReadMem    <= 1'b0;
      WriteMem   <= 1'b0;
      jump_en    <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
      retired    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ir       <= w_ir_nxt;
      r_wait     <= (r_state == S_MEM && w_state_nxt == S_MEM) ? r_wait + TO_W'(1) : '0;
      r_beq_exec <= (w_state_nxt == S_EXEC) && (w_op == kBEQ);
      fetch_req  <= (w_state_nxt == S_FETCH);
      rAddrA     <= w_addr_live ? w_addr_a : '0;
      rAddrB     <= w_addr_live ? w_addr_b : '0;
      wAddr      <= w_addr_live ? w_addr_w : '0;
      write_en   <= (w_state_nxt == S_WB);
      ReadMem    <= (w_state_nxt == S_MEM) && (w_op == kLOAD);
      WriteMem   <= (w_state_nxt == S_MEM) && (w_op == kSTORE);
      jump_en    <= (w_state_nxt == S_EXEC) && (w_op == kJUMP);
      halted     <= (w_state_nxt == S_HALTED);
      if (w_timeout) fault <= 1'b1;
      if (w_retire) retired <= retired + CNT_W'(1);
    end
  end

  // The ALU result is stable by EXEC, so the branch decision follows Zero directly.
  assign branch_en = r_beq_exec & Zero;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: per-instruction expected records vs. observed behaviour.
module tb_ctrl_sequencer;

  localparam int unsigned IW     = 9;
  localparam int unsigned RA_W   = 3;
  localparam int unsigned MEM_TO = 15;

  typedef struct packed {
    logic [7:0]  lat;
    logic [3:0]  n_we;
    logic [2:0]  waddr;
    logic [2:0]  raddra;
    logic [2:0]  raddrb;
    logic [3:0]  n_jump;
    logic [3:0]  n_branch;
    logic [4:0]  n_rd;
    logic [4:0]  n_wr;
    logic        halted;
    logic        fault;
    logic [15:0] ret;
    logic [1:0]  ret2;
    logic [3:0]  excl;
  } rec_t;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic [IW-1:0] Instr = '0;
  logic          instr_valid = 1'b0;
  logic          Zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          fetch_req, write_en, ReadMem, WriteMem, jump_en, branch_en, halted, fault;
  logic [2:0]    rAddrA, rAddrB, wAddr;
  logic [15:0]   retired;
  logic          fetch_req2, write_en2, ReadMem2, WriteMem2, jump_en2, branch_en2, halted2, fault2;
  logic [2:0]    rAddrA2, rAddrB2, wAddr2;
  logic [1:0]    retired2;

  int          checks = 0;
  int          failures = 0;
  rec_t        sb[$];
  logic [15:0] exp_ret = '0;

  always #5 Clk = ~Clk;

  ctrl_sequencer #(.IW(IW), .RA_W(RA_W), .ACC(0), .MEM_TO(MEM_TO), .CNT_W(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Instr(Instr), .instr_valid(instr_valid), .Zero(Zero),
    .mem_ready(mem_ready), .fetch_req(fetch_req), .rAddrA(rAddrA), .rAddrB(rAddrB),
    .wAddr(wAddr), .write_en(write_en), .ReadMem(ReadMem), .WriteMem(WriteMem),
    .jump_en(jump_en), .branch_en(branch_en), .halted(halted), .fault(fault), .retired(retired)
  );

  ctrl_sequencer #(.IW(IW), .RA_W(RA_W), .ACC(0), .MEM_TO(MEM_TO), .CNT_W(2)) dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .Instr(Instr), .instr_valid(instr_valid), .Zero(Zero),
    .mem_ready(mem_ready), .fetch_req(fetch_req2), .rAddrA(rAddrA2), .rAddrB(rAddrB2),
    .wAddr(wAddr2), .write_en(write_en2), .ReadMem(ReadMem2), .WriteMem(WriteMem2),
    .jump_en(jump_en2), .branch_en(branch_en2), .halted(halted2), .fault(fault2), .retired(retired2)
  );

  // Reference behaviour of one instruction, independent of the RTL structure.
  function automatic rec_t model(input logic [8:0] ins, input int dly, input bit zero,
                                 input logic [15:0] ret);
    rec_t e;
    logic [2:0] op, ra, rb;
    int mem;
    bit tmo;
    e   = '0;
    op  = ins[8:6];
    ra  = ins[5:3];
    rb  = ins[2:0];
    tmo = (dly >= int'(MEM_TO));
    mem = tmo ? int'(MEM_TO) : dly + 1;
    case (op)
      3'd0, 3'd5: begin e.raddra = ra; e.raddrb = rb; e.waddr = ra; e.n_we = 1; e.lat = 4; end
      3'd1:       begin e.raddrb = rb; e.n_we = 1; e.lat = 4; end
      3'd2:       begin e.raddra = ra; e.raddrb = rb; e.n_wr = 5'(mem); e.lat = 8'(3 + mem); end
      3'd3:       begin e.raddra = rb; e.waddr = ra; e.n_rd = 5'(mem); e.n_we = 1; e.lat = 8'(4 + mem); end
      3'd4:       begin e.raddrb = rb; e.n_jump = 1; e.lat = 3; end
      3'd6:       begin e.raddra = ra; e.raddrb = rb; e.n_branch = 4'(zero); e.lat = 3; end
      default:    begin e.raddra = rb; e.waddr = ra; e.n_we = 1; e.lat = 4; end
    endcase
    e.ret = ret + 16'd1;
    if ((op == 3'd2 || op == 3'd3) && tmo) begin
      e.n_we = 0; e.waddr = 0; e.lat = 8'(3 + MEM_TO); e.fault = 1; e.halted = 1; e.ret = ret;
    end
    if (ins == 9'h1FF) begin
      e.n_we = 0; e.waddr = 0; e.lat = 2; e.halted = 1; e.ret = ret;
    end
    e.ret2 = e.ret[1:0];
    return e;
  endfunction

  // Drive one instruction, push its expectation, and monitor until the next fetch or halt.
  task automatic issue(input logic [8:0] ins, input int dly, input bit zero, output rec_t obs);
    int cyc, nmem;
    bit done;
    obs = '0;
    for (int w = 0; w < 20 && fetch_req !== 1'b1; w++) begin
      @(posedge Clk); #1;
    end
    sb.push_back(model(ins, dly, zero, exp_ret));
    exp_ret = sb[$].ret;
    Instr = ins; instr_valid = 1'b1; Zero = zero;
    cyc = 0; nmem = 0; done = 1'b0;
    while (!done && cyc < 60) begin
      @(posedge Clk); #1;
      instr_valid = 1'b0;
      cyc++;
      if (fetch_req === 1'b1 || halted === 1'b1) begin
        done = 1'b1;
      end else begin
        if (cyc == 1) begin obs.raddra = rAddrA; obs.raddrb = rAddrB; end
        if (write_en === 1'b1) begin obs.n_we = obs.n_we + 4'd1; obs.waddr = wAddr; end
        if (jump_en === 1'b1) obs.n_jump = obs.n_jump + 4'd1;
        if (branch_en === 1'b1) obs.n_branch = obs.n_branch + 4'd1;
        if (ReadMem === 1'b1) obs.n_rd = obs.n_rd + 5'd1;
        if (WriteMem === 1'b1) obs.n_wr = obs.n_wr + 5'd1;
        if ((ReadMem && WriteMem) || ((ReadMem || WriteMem) && (write_en || jump_en || branch_en)))
          obs.excl = obs.excl + 4'd1;
        if (ReadMem || WriteMem) begin
          nmem++;
          mem_ready = (nmem > dly);
        end else begin
          mem_ready = 1'b0;
        end
      end
    end
    mem_ready = 1'b0;
    obs.lat = 8'(cyc); obs.halted = halted; obs.fault = fault;
    obs.ret = retired; obs.ret2 = retired2;
  endtask

  task automatic test_reset;
    logic [63:0] snap;
    repeat (2) @(posedge Clk);
    #1;
    snap = {fetch_req, write_en, ReadMem, WriteMem, jump_en, branch_en, halted, fault, rAddrA, rAddrB,
            wAddr, retired, fetch_req2, write_en2, ReadMem2, WriteMem2, jump_en2, branch_en2, halted2,
            fault2, rAddrA2, rAddrB2, wAddr2, retired2};
    checks++;
    if (snap !== '0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", snap); end
    Reset_n = 1'b1;
    checks++;
    if (fetch_req !== 1'b0) begin failures++; $display("FAIL reset_no_early_fetch: got %b expected 0", fetch_req); end
    @(posedge Clk); #1;
    checks++;
    if (fetch_req !== 1'b1) begin failures++; $display("FAIL reset_first_fetch: got %b expected 1", fetch_req); end
  endtask

  task automatic test_alu;
    rec_t obs, exp;
    issue(9'b001_000_101, 0, 1'b0, obs);
    exp = sb.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL alu: got %h expected %h", obs, exp); end
  endtask

  task automatic test_load_late;
    rec_t obs, exp;
    issue(9'b011_010_011, 2, 1'b0, obs);
    exp = sb.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL load_late: got %h expected %h", obs, exp); end
  endtask

  task automatic test_beq;
    rec_t obs, exp;
    issue(9'b110_001_010, 0, 1'b1, obs);
    exp = sb.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL beq_taken: got %h expected %h", obs, exp); end
    issue(9'b110_011_100, 0, 1'b0, obs);
    exp = sb.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL beq_not_taken: got %h expected %h", obs, exp); end
  endtask

  task automatic test_opcodes;
    logic [8:0] tbl [7];
    rec_t obs, exp;
    tbl = '{9'b000_110_001, 9'b010_101_011, 9'b100_000_110, 9'b101_111_010,
            9'b111_011_101, 9'b011_100_111, 9'b001_110_011};
    foreach (tbl[i]) begin
      issue(tbl[i], 0, 1'b1, obs);
      exp = sb.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("FAIL opcode_%0d: got %h expected %h", i, obs, exp); end
    end
  endtask

  task automatic test_mem_boundary;
    rec_t obs, exp;
    issue(9'b010_011_001, int'(MEM_TO) - 1, 1'b0, obs);
    exp = sb.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL store_last_cycle: got %h expected %h", obs, exp); end
    issue(9'b011_001_100, int'(MEM_TO) - 1, 1'b0, obs);
    exp = sb.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL load_last_cycle: got %h expected %h", obs, exp); end
  endtask

  task automatic test_back_to_back;
    rec_t obs, exp;
    logic [8:0] ins;
    for (int i = 0; i < 20; i++) begin
      ins = 9'($urandom_range(0, 511));
      if (ins == 9'h1FF) ins = 9'h1FE;
      issue(ins, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), obs);
      exp = sb.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("FAIL b2b_%0d ins=%h: got %h expected %h", i, ins, obs, exp); end
    end
  endtask

  task automatic test_timeout;
    rec_t obs, exp;
    issue(9'b010_001_010, 1000, 1'b0, obs);
    exp = sb.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL store_timeout: got %h expected %h", obs, exp); end
    checks++;
    if (WriteMem !== 1'b0 || fault !== 1'b1) begin
      failures++; $display("FAIL timeout_state: got wm=%b fault=%b expected wm=0 fault=1", WriteMem, fault);
    end
  endtask

  task automatic test_reset_mid_load;
    rec_t obs, exp;
    logic [30:0] snap;
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b1; exp_ret = '0;
    @(posedge Clk); #1;
    issue(9'b001_000_010, 0, 1'b0, obs);
    exp = sb.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL pre_reset_alu: got %h expected %h", obs, exp); end
    Instr = 9'b011_001_010; instr_valid = 1'b1;
    @(posedge Clk); #1; instr_valid = 1'b0;
    repeat (2) begin @(posedge Clk); #1; end
    checks++;
    if (ReadMem !== 1'b1) begin failures++; $display("FAIL midload_readmem: got %b expected 1", ReadMem); end
    #2 Reset_n = 1'b0;
    #1;
    snap = {ReadMem, WriteMem, write_en, fetch_req, rAddrA, rAddrB, wAddr, retired, halted, fault};
    checks++;
    if (snap !== '0) begin failures++; $display("FAIL midload_async_clear: got %h expected 0", snap); end
    @(posedge Clk); #1;
    Reset_n = 1'b1; exp_ret = '0;
    @(posedge Clk); #1;
    checks++;
    if (fetch_req !== 1'b1 || retired !== 16'd0) begin
      failures++; $display("FAIL midload_release: got fetch=%b ret=%0d expected fetch=1 ret=0", fetch_req, retired);
    end
  endtask

  task automatic test_halt_wrap;
    rec_t obs, exp;
    int nf;
    for (int i = 0; i < 5; i++) begin
      issue(9'(9'b001_000_000 + i), 0, 1'b0, obs);
      exp = sb.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("FAIL wrap_alu_%0d: got %h expected %h", i, obs, exp); end
    end
    issue(9'h1FF, 0, 1'b0, obs);
    exp = sb.pop_front(); checks++;
    if (obs !== exp) begin failures++; $display("FAIL halt: got %h expected %h", obs, exp); end
    Instr = 9'b001_000_001; instr_valid = 1'b1; nf = 0;
    repeat (10) begin
      @(posedge Clk); #1;
      if (fetch_req !== 1'b0) nf++;
    end
    instr_valid = 1'b0;
    checks++;
    if (nf != 0 || halted !== 1'b1 || retired !== 16'd5) begin
      failures++; $display("FAIL halt_sticky: got fetches=%0d halted=%b ret=%0d expected 0 1 5", nf, halted, retired);
    end
    checks++;
    if (retired2 !== 2'd1) begin failures++; $display("FAIL retired_wrap: got %0d expected 1", retired2); end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_load_late;
    test_beq;
    test_opcodes;
    test_mem_boundary;
    test_back_to_back;
    test_timeout;
    test_reset_mid_load;
    test_halt_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
